// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply/divide unit for the minicpu execute stage.
//
// Each operation takes XLEN iterations, one per clock edge. The result then comes back
// as a single register-file write-back.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active low
//   start    in   request a new operation (sampled only in IDLE)
//   op       in   00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   rs1_val  in   multiplicand / dividend
//   rs2_val  in   multiplier / divisor
//   rd_addr  in   destination register
//   busy     out  high from the accepting edge through the write-back cycle
//   wb_we    out  one-cycle write-enable pulse (never for x0)
//   wb_addr  out  write-back destination register
//   wb_data  out  write-back result
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [4:0]      rd_addr,
   output logic            busy,
   output logic            wb_we,
   output logic [4:0]      wb_addr,
   output logic [XLEN-1:0] wb_data
);

   localparam int unsigned      CntW    = $clog2(XLEN);
   localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          r_state, w_state_nxt;
   logic [CntW-1:0] r_cnt;
   logic [1:0]      r_op;
   logic [XLEN-1:0] r_b;        // multiplicand / divisor
   logic [XLEN-1:0] r_hi;       // product high half / partial remainder
   logic [XLEN-1:0] r_lo;       // multiplier bits / dividend-then-quotient bits
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_wb_data;
   logic [4:0]      r_wb_addr;

   logic            w_last;
   logic [XLEN:0]   w_mul_sum;
   logic [XLEN:0]   w_div_shift;
   logic            w_div_ge;
   logic [XLEN-1:0] w_div_diff;
   logic [XLEN-1:0] w_hi_nxt;
   logic [XLEN-1:0] w_lo_nxt;
   logic [XLEN-1:0] w_result;

   assign w_last = (r_cnt == LastCnt);

   // Shift-add step: conditionally add the multiplicand into the high half, then shift the
   // whole {carry, hi, lo} right by one. The multiplier bits drain out of lo as product
   // bits fill it.
   assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

   // Restoring step: shift the next dividend bit into the remainder and subtract the
   // divisor if it fits. The difference is narrower than the shift on purpose: when
   // ge holds, the result is below the divisor. A zero divisor always fits, so the
   // quotient becomes all ones and the remainder becomes the dividend with no special
   // case needed.
   assign w_div_shift = {r_hi, r_lo[XLEN-1]};
   assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
   assign w_div_diff  = w_div_shift[XLEN-1:0] - r_b;

   always_comb begin
      w_hi_nxt = r_hi;
      w_lo_nxt = r_lo;
      if (r_op[1]) begin
         w_hi_nxt = w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0];
         w_lo_nxt = {r_lo[XLEN-2:0], w_div_ge};
      end else begin
         w_hi_nxt = w_mul_sum[XLEN:1];
         w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
      end
   end

   // op[0] picks the high register: MULHU's upper product or REMU's remainder.
   assign w_result = r_op[0] ? w_hi_nxt : w_lo_nxt;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle:  if (start) w_state_nxt = StRun;
         StRun:   if (w_last) w_state_nxt = StDone;
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt     <= '0;
         r_op      <= '0;
         r_b       <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_rd      <= '0;
         r_wb_data <= '0;
         r_wb_addr <= '0;
      end else if (r_state == StIdle) begin
         if (start) begin
            r_cnt <= '0;
            r_op  <= op;
            r_b   <= rs2_val;
            r_hi  <= '0;
            r_lo  <= rs1_val;
            r_rd  <= rd_addr;
         end
      end else if (r_state == StRun) begin
         r_cnt <= r_cnt + 1'b1;
         r_hi  <= w_hi_nxt;
         r_lo  <= w_lo_nxt;
         // Capture the result on the final iteration so it is valid throughout DONE and
         // held afterwards.
         if (w_last) begin
            r_wb_data <= w_result;
            r_wb_addr <= r_rd;
         end
      end
   end

   assign busy    = (r_state != StIdle);
   assign wb_we   = (r_state == StDone) && (r_rd != 5'd0);
   assign wb_addr = r_wb_addr;
   assign wb_data = r_wb_data;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (XLEN = 32).
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [4:0]  rd_addr;
   logic        busy;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   int n_checks = 0;
   int n_fail   = 0;

   // Observations gathered over one operation window (cycle c = between edge Ec and Ec+1).
   logic [31:0] c_data;
   logic [4:0]  c_addr;
   int          c_we_cnt;
   int          c_we_first;
   int          c_busy_hi;
   int          c_busy_low_first;

   muldiv_unit #(.XLEN(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .rd_addr (rd_addr),
      .busy    (busy),
      .wb_we   (wb_we),
      .wb_addr (wb_addr),
      .wb_data (wb_data)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   // Present an operation and let edge E0 accept it; then scramble the inputs.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      @(negedge clk);
      op = o; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h0BAD_F00D; rd_addr = 5'd31;
      op = ~o;
   endtask

   // Sample 40 cycles after E0; optionally raise start during cycle poke_cyc.
   task automatic collect(input int poke_cyc);
      c_data = 'x; c_addr = 'x;
      c_we_cnt = 0; c_we_first = -1; c_busy_hi = 0; c_busy_low_first = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (wb_we === 1'b1) begin
            c_we_cnt++;
            if (c_we_first < 0) c_we_first = c;
         end
         if (busy === 1'b1) c_busy_hi++;
         else if (c_busy_low_first < 0) c_busy_low_first = c;
         if (c == 32) begin
            c_data = wb_data;
            c_addr = wb_addr;
         end
         if (c == poke_cyc) begin
            start = 1'b1; op = 2'b00; rs1_val = 32'd5; rs2_val = 32'd5; rd_addr = 5'd9;
         end else begin
            start = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; op = 2'b00; rs1_val = '0; rs2_val = '0; rd_addr = '0;
      #12;
      n_checks++;
      if (busy !== 1'b0 || wb_we !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b we=%b addr=%0d data=%h want 0 0 0 0",
                  busy, wb_we, wb_addr, wb_data);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_mul_basic();
      issue(2'b00, 32'd7, 32'd6, 5'd5);
      collect(-1);
      n_checks++;
      if (c_busy_hi !== 33) begin
         n_fail++; $display("FAIL mul_busy_cycles: got %0d want 33", c_busy_hi);
      end
      n_checks++;
      if (c_busy_low_first !== 33) begin
         n_fail++; $display("FAIL mul_busy_fall: got %0d want 33", c_busy_low_first);
      end
      n_checks++;
      if (c_we_cnt !== 1 || c_we_first !== 32) begin
         n_fail++;
         $display("FAIL mul_we_timing: got cnt=%0d first=%0d want cnt=1 first=32",
                  c_we_cnt, c_we_first);
      end
      n_checks++;
      if (c_data !== 32'd42 || c_addr !== 5'd5) begin
         n_fail++;
         $display("FAIL mul_result: got data=%0d addr=%0d want 42 5", c_data, c_addr);
      end
   endtask

   task automatic test_vectors();
      logic [1:0]  v_op [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11};
      logic [31:0] v_a  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] v_b  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd1, 32'd1};
      logic [31:0] v_r  [6] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'd14, 32'd2,
                                32'hFFFF_FFFF, 32'd0};
      for (int i = 0; i < 6; i++) begin
         logic [4:0] rd;
         rd = 5'(i + 1);
         issue(v_op[i], v_a[i], v_b[i], rd);
         collect(-1);
         n_checks++;
         if (c_data !== v_r[i] || c_addr !== rd) begin
            n_fail++;
            $display("FAIL vector_%0d: got data=%h addr=%0d want %h %0d",
                     i, c_data, c_addr, v_r[i], rd);
         end
         n_checks++;
         if (c_we_cnt !== 1 || c_we_first !== 32) begin
            n_fail++;
            $display("FAIL vector_%0d_we: got cnt=%0d first=%0d want 1 32",
                     i, c_we_cnt, c_we_first);
         end
      end
   endtask

   task automatic test_div_zero();
      logic [1:0]  v_op [2] = '{2'b10, 2'b11};
      logic [31:0] v_r  [2] = '{32'hFFFF_FFFF, 32'h0000_1234};
      for (int i = 0; i < 2; i++) begin
         issue(v_op[i], 32'h0000_1234, 32'd0, 5'd10);
         collect(-1);
         n_checks++;
         if (c_data !== v_r[i]) begin
            n_fail++;
            $display("FAIL divzero_%0d: got %h want %h", i, c_data, v_r[i]);
         end
         n_checks++;
         if (c_we_first !== 32 || c_busy_low_first !== 33) begin
            n_fail++;
            $display("FAIL divzero_%0d_latency: got we@%0d idle@%0d want 32 33",
                     i, c_we_first, c_busy_low_first);
         end
      end
   endtask

   task automatic test_rd_zero();
      issue(2'b00, 32'd3, 32'd3, 5'd0);
      collect(9);  // start raised so that E10 sees it; must be ignored
      n_checks++;
      if (c_we_cnt !== 0) begin
         n_fail++; $display("FAIL rd0_we: got %0d pulses want 0", c_we_cnt);
      end
      n_checks++;
      if (c_busy_hi !== 33 || c_busy_low_first !== 33) begin
         n_fail++;
         $display("FAIL rd0_busy: got hi=%0d fall=%0d want 33 33", c_busy_hi, c_busy_low_first);
      end
      n_checks++;
      if (c_data !== 32'd9 || c_addr !== 5'd0) begin
         n_fail++;
         $display("FAIL rd0_result: got data=%0d addr=%0d want 9 0", c_data, c_addr);
      end
   endtask

   task automatic test_back_to_back();
      logic b33, b34;
      int   we1;
      @(negedge clk);
      op = 2'b00; rs1_val = 32'd2; rs2_val = 32'd2; rd_addr = 5'd4; start = 1'b1;
      @(posedge clk);
      we1 = -1; b33 = 1'bx; b34 = 1'bx;
      for (int c = 0; c <= 34; c++) begin
         @(negedge clk);
         if (wb_we === 1'b1 && we1 < 0) we1 = c;
         if (c == 33) b33 = busy;
         if (c == 34) begin
            b34 = busy;
            start = 1'b0;
         end
      end
      n_checks++;
      if (b33 !== 1'b0 || b34 !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_accept: got busy@33=%b busy@34=%b want 0 1", b33, b34);
      end
      n_checks++;
      if (we1 !== 32) begin
         n_fail++; $display("FAIL b2b_first_we: got %0d want 32", we1);
      end
      collect(-1);  // index 0 here is cycle 1 of the second operation
      n_checks++;
      if (c_we_cnt !== 1 || c_we_first !== 31 || c_data !== 32'd4) begin
         n_fail++;
         $display("FAIL b2b_second: got cnt=%0d first=%0d data=%0d want 1 31 4",
                  c_we_cnt, c_we_first, c_data);
      end
   endtask

   task automatic test_async_reset();
      issue(2'b00, 32'd7, 32'd6, 5'd5);
      for (int c = 0; c <= 15; c++) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;  // still before the next rising edge
      n_checks++;
      if (busy !== 1'b0 || wb_we !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 32'd0) begin
         n_fail++;
         $display("FAIL async_reset: got busy=%b we=%b addr=%0d data=%h want 0 0 0 0",
                  busy, wb_we, wb_addr, wb_data);
      end
      @(negedge clk);
      rst = 1'b1;
      collect(-1);
      n_checks++;
      if (c_we_cnt !== 0 || c_busy_hi !== 0) begin
         n_fail++;
         $display("FAIL reset_stale: got we=%0d busy=%0d want 0 0", c_we_cnt, c_busy_hi);
      end
      issue(2'b00, 32'd2, 32'd3, 5'd7);
      collect(-1);
      n_checks++;
      if (c_data !== 32'd6 || c_addr !== 5'd7 || c_we_first !== 32 || c_we_cnt !== 1) begin
         n_fail++;
         $display("FAIL post_reset_mul: got data=%0d addr=%0d we@%0d cnt=%0d want 6 7 32 1",
                  c_data, c_addr, c_we_first, c_we_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_mul_basic();
      test_vectors();
      test_div_zero();
      test_rd_zero();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
